// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder controller:
// controller state encoding, default operand width and a
// constant-evaluable ceil(log2) helper used to size the bit counter.
package serial_adder_pkg;

    // Default operand/result width when the top is not overridden.
    localparam int SA_WIDTH_DEFAULT = 8;

    // Controller states: waiting for start, shifting bits, result pulse.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } sa_state_t;

    // Smallest r with 2**r >= value; used at elaboration time only.
    function automatic int clog2(input int value);
        int res;
        res = 0;
        while ((1 << res) < value) begin
            res = res + 1;
        end
        return res;
    endfunction

endpackage

// File: rtl/serial_adder_ctrl_fa_cell.sv
// One-bit full adder cell. The serial controller reuses this single
// cell once per clock to walk through the operand bits LSB first.
module fa_cell (
    input  logic a_i,
    input  logic b_i,
    input  logic ci_i,
    output logic s_o,
    output logic co_o
);

    assign s_o  = a_i ^ b_i ^ ci_i;
    assign co_o = (a_i & b_i) | (a_i & ci_i) | (b_i & ci_i);

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller. A start pulse in IDLE latches the
// operands and carry-in; one bit pair per clock then passes through a
// single full-adder cell, the result shifts into the sum register from
// the MSB side, and a one-cycle done pulse marks a valid {cout,sum}.
// Optional macro SERIAL_ADD_SUB_EN adds a 'sub' input that turns the
// operation into a - b (cout=1 means no borrow).
module serial_adder_ctrl
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = SA_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SERIAL_ADD_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CNT_W = clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    sa_state_t        state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
`ifdef SERIAL_ADD_SUB_EN
    logic             sub_q, sub_d;
`endif

    logic accept;
    logic last_bit;
    logic init_carry;
    logic cell_a, cell_b, cell_s, cell_co;

    // A start is only honoured while idle; the counter stops at WIDTH-1.
    assign accept   = (state_q == IDLE) && start;
    assign last_bit = (cnt_q == LAST_BIT);

`ifdef SERIAL_ADD_SUB_EN
    // Subtraction is a + ~b + 1, so the B bit is inverted and carry seeded with 1.
    assign init_carry = sub ? 1'b1 : cin;
    assign cell_b     = b_q[0] ^ sub_q;
`else
    assign init_carry = cin;
    assign cell_b     = b_q[0];
`endif
    assign cell_a = a_q[0];

    fa_cell u_fa_cell (
        .a_i  (cell_a),
        .b_i  (cell_b),
        .ci_i (carry_q),
        .s_o  (cell_s),
        .co_o (cell_co)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: DONE always falls back to IDLE after one cycle.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start)    state_d = ADD;
            ADD:     if (last_bit) state_d = DONE;
            DONE:                  state_d = IDLE;
            default:               state_d = IDLE;
        endcase
    end

    // Output decode from the current state.
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        unique case (state_q)
            ADD:     busy = 1'b1;
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    // Datapath next-state: latch on accept, shift one bit per ADD cycle.
    always_comb begin
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        cout_d  = cout_q;
`ifdef SERIAL_ADD_SUB_EN
        sub_d   = sub_q;
`endif
        if (accept) begin
            a_d     = a;
            b_d     = b;
            cnt_d   = '0;
            carry_d = init_carry;
`ifdef SERIAL_ADD_SUB_EN
            sub_d   = sub;
`endif
        end else if (state_q == ADD) begin
            a_d     = a_q >> 1;
            b_d     = b_q >> 1;
            sum_d   = {cell_s, sum_q[WIDTH-1:1]};
            carry_d = cell_co;
            if (last_bit) begin
                cout_d = cell_co;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // Datapath registers; reset clears everything so an abort leaves no stale result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
`ifdef SERIAL_ADD_SUB_EN
            sub_q   <= 1'b0;
`endif
        end else begin
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
`ifdef SERIAL_ADD_SUB_EN
            sub_q   <= sub_d;
`endif
        end
    end

    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl (WIDTH=8). Expected results
// come from plain integer arithmetic on the operands.
module tb_serial_adder_ctrl;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    serial_adder_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
`ifdef SERIAL_ADD_SUB_EN
        .sub   (sub),
`endif
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: addition is a+b+cin; subtraction is a-b with cout = no borrow.
    function automatic logic [W:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                         input logic c, input logic s);
        int unsigned r;
        if (s) begin
            r = (int'(x) - int'(y)) & ((1 << W) - 1);
            return {(x >= y), r[W-1:0]};
        end
        r = int'(x) + int'(y) + int'(c);
        return r[W:0];
    endfunction

    // Run one operation; ends one edge after done (back in IDLE).
    task automatic do_op(input string tag, input logic [W-1:0] xa, input logic [W-1:0] xb,
                         input logic xc, input logic xs, input bit scramble);
        logic [W:0] exp_v;
        logic [W:0] got;
        int done_edge;
        int ndone;
        int busy_cnt;
        exp_v = model(xa, xb, xc, xs);
        a = xa; b = xb; cin = xc; sub = xs; start = 1'b1;
        tick();
        start = 1'b0;
        busy_cnt = busy ? 1 : 0;
        done_edge = -1;
        ndone = 0;
        got = '0;
        for (int k = 1; k <= W + 4 && done_edge < 0; k++) begin
            if (scramble) begin
                a = W'($urandom);
                b = W'($urandom);
                cin = 1'($urandom_range(0, 1));
                sub = 1'($urandom_range(0, 1));
                start = 1'($urandom_range(0, 1));
            end
            tick();
            if (busy) busy_cnt++;
            if (done) begin
                ndone++;
                done_edge = k;
                got = {cout, sum};
            end
        end
        start = scramble;
        tick();
        start = 1'b0;
        if (done) ndone++;
        check({tag, ".busy_cycles"}, 64'(busy_cnt), 64'(W));
        check({tag, ".done_edge"}, 64'(done_edge), 64'(W));
        check({tag, ".done_pulses"}, 64'(ndone), 64'd1);
        check({tag, ".result"}, 64'(got), 64'(exp_v));
        check({tag, ".idle_after"}, 64'(busy), 64'd0);
    endtask

    initial begin
        int nd;
        rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        tick();
        tick();
        check("reset.busy", 64'(busy), 64'd0);
        check("reset.done", 64'(done), 64'd0);
        check("reset.sum",  64'(sum),  64'd0);
        check("reset.cout", 64'(cout), 64'd0);
        rst = 1'b0;
        tick();

        do_op("ff_01", 8'hFF, 8'h01, 1'b0, 1'b0, 1'b0);
        repeat (3) tick();
        check("ff_01.held_sum",  64'(sum),  64'h00);
        check("ff_01.held_cout", 64'(cout), 64'd1);

        do_op("a5_5a", 8'hA5, 8'h5A, 1'b1, 1'b0, 1'b0);
        do_op("12_34_b2b", 8'h12, 8'h34, 1'b0, 1'b0, 1'b0);
        do_op("03_04_ovl", 8'h03, 8'h04, 1'b0, 1'b0, 1'b1);
        do_op("0f_01_chg", 8'h0F, 8'h01, 1'b0, 1'b0, 1'b1);
        do_op("f0_20", 8'hF0, 8'h20, 1'b0, 1'b0, 1'b0);

        // Abort mid-operation with an asynchronous reset.
        a = 8'h80; b = 8'h80; cin = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) tick();
        #2 rst = 1'b1;
        #1;
        check("abort.busy", 64'(busy), 64'd0);
        check("abort.done", 64'(done), 64'd0);
        check("abort.sum",  64'(sum),  64'd0);
        check("abort.cout", 64'(cout), 64'd0);
        tick();
        rst = 1'b0;
        nd = 0;
        for (int k = 0; k < W + 3; k++) begin
            tick();
            if (done || busy) nd++;
        end
        check("abort.no_activity", 64'(nd), 64'd0);
        do_op("80_80_fresh", 8'h80, 8'h80, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 24; i++) begin
            do_op($sformatf("rand%0d", i), W'($urandom), W'($urandom),
                  1'($urandom_range(0, 1)), 1'b0, (i % 4) == 3);
        end

`ifdef SERIAL_ADD_SUB_EN
        do_op("sub_10_01", 8'h10, 8'h01, 1'b0, 1'b1, 1'b0);
        do_op("sub_01_02", 8'h01, 8'h02, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) begin
            do_op($sformatf("subrand%0d", i), W'($urandom), W'($urandom),
                  1'($urandom_range(0, 1)), 1'b1, 1'b0);
        end
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
